// File: rtl/instruction_fetch_stage.sv
// Fetch stage: issues one instruction-cache read at a time and buffers
// {PC, instruction} pairs in a small FIFO for decode; a mispredict squashes wrong-path work.
module instruction_fetch_stage #(
  parameter int                    ADDRESS_WIDTH   = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    FIFO_DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTRUCTION = 32'h00000013
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ADDRESS_WIDTH-1:0] PC,
  input  logic                     PC_VALID,
  input  logic                     PC_MISPREDICT_SELECT,
  input  logic                     STALL_INSTRUCTION_FETCH_STAGE,
  input  logic [DATA_WIDTH-1:0]    INSTRUCTION_FROM_CACHE,
  input  logic                     INSTRUCTION_FROM_CACHE_READY,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS_TO_CACHE,
  output logic                     ADDRESS_TO_CACHE_VALID,
  output logic                     STALL_PROGRAME_COUNTER_STAGE,
  output logic [DATA_WIDTH-1:0]    INSTRUCTION,
  output logic [ADDRESS_WIDTH-1:0] PC_FETCHED,
  output logic                     INSTRUCTION_VALID
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WAIT_SQUASH
  } state_t;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } entry_t;

  state_t                   state;
  entry_t                   mem [FIFO_DEPTH];
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  logic [CW-1:0]            count;
  logic [ADDRESS_WIDTH-1:0] pc_req;

  logic          flush;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occ_next;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    flush    = PC_MISPREDICT_SELECT;
    pop      = 1'b0;
    push     = 1'b0;
    issue    = 1'b0;
    occ_next = '0;
    pop      = INSTRUCTION_VALID && !STALL_INSTRUCTION_FETCH_STAGE && !flush;
    push     = (state == S_WAIT) && INSTRUCTION_FROM_CACHE_READY && !flush;
    occ_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    // The response slot is reserved at issue time, so a returning fetch always fits.
    issue    = !RST && !flush && PC_VALID
               && (occ_next <= (CW+1)'(FIFO_DEPTH - 1))
               && ((state == S_IDLE) || INSTRUCTION_FROM_CACHE_READY);
  end

  assign ADDRESS_TO_CACHE             = PC;
  assign ADDRESS_TO_CACHE_VALID       = issue;
  assign STALL_PROGRAME_COUNTER_STAGE = RST || !(issue || flush);

  assign INSTRUCTION_VALID = (count != '0);
  assign INSTRUCTION       = INSTRUCTION_VALID ? mem[rd_ptr].instr : NOP_INSTRUCTION;
  assign PC_FETCHED        = INSTRUCTION_VALID ? mem[rd_ptr].pc : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pc_req <= '0;
    end else begin
      if (issue) pc_req <= PC;

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        count <= occ_next[CW-1:0];
      end

      case (state)
        S_IDLE: begin
          if (issue) state <= S_WAIT;
        end
        S_WAIT: begin
          if (INSTRUCTION_FROM_CACHE_READY) state <= issue ? S_WAIT : S_IDLE;
          else if (flush)                   state <= S_WAIT_SQUASH;
        end
        S_WAIT_SQUASH: begin
          if (INSTRUCTION_FROM_CACHE_READY) state <= issue ? S_WAIT : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the buffer storage is deliberately not reset; count gates every read of it.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{pc: pc_req, instr: INSTRUCTION_FROM_CACHE};
  end

endmodule
